// File: rtl/except_unit.sv
// -----------------------------------------------------------------------------
// except_unit
//
// Purpose:
//   MEM-stage exception arbiter for a MIPS-style pipeline. Collects the
//   per-instruction exception flags and the pending-interrupt condition. It
//   selects the highest-priority cause and drives the CP0 update fields. It
//   also drives the pipeline flush/redirect. After a flush, a one-cycle
//   SQUASH state blocks any further exception from being issued. This covers
//   the instruction that follows the faulting one into MEM.
//
// Configuration macro:
//   TRAP_EXC_EN  -- when defined, exc_trap_i raises code 0xd at its priority
//                   slot (between break and overflow). When undefined,
//                   exc_trap_i is ignored and 0xd is never produced.
//
// Parameters:
//   EXC_VECTOR   exception handler entry address (redirect for all codes
//                except ERET)
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous active-high reset
//   stall_i              MEM stage stalled: state holds, nothing issued
//   valid_i              MEM stage holds a real instruction (not a bubble)
//   pc_i                 PC of the MEM-stage instruction
//   is_in_delayslot_i    MEM-stage instruction is in a branch delay slot
//   mem_addr_i           data address of the MEM-stage load/store
//   exc_adel_if_i        instruction fetch address misaligned
//   exc_ri_i             reserved instruction
//   exc_sys_i            syscall
//   exc_brk_i            break
//   exc_trap_i           trap condition (only with TRAP_EXC_EN)
//   exc_ov_i             arithmetic overflow
//   exc_adel_i           load address misaligned
//   exc_ades_i           store address misaligned
//   eret_i               exception return
//   status_i/cause_i/epc_i  current CP0 Status, Cause, EPC
//   excepttype_o         exception code to CP0 (0 = none)
//   current_inst_addr_o  faulting PC to CP0 (pass-through)
//   is_in_delayslot_o    delay-slot flag to CP0 (pass-through)
//   bad_addr_o           BadVAddr value to CP0
//   flush_o              pipeline flush pulse
//   newpc_o              redirect target, valid while flush_o=1
// -----------------------------------------------------------------------------
module except_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        exc_adel_if_i,
    input  logic        exc_ri_i,
    input  logic        exc_sys_i,
    input  logic        exc_brk_i,
    input  logic        exc_ov_i,
    input  logic        exc_adel_i,
    input  logic        exc_ades_i,
    input  logic        eret_i,
    input  logic        exc_trap_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    // Exception codes as written to Cause.ExcCode / excepttype.
    localparam logic [31:0] CODE_NONE = 32'h0;
    localparam logic [31:0] CODE_INT  = 32'h1;
    localparam logic [31:0] CODE_ADEL = 32'h4;
    localparam logic [31:0] CODE_ADES = 32'h5;
    localparam logic [31:0] CODE_SYS  = 32'h8;
    localparam logic [31:0] CODE_BRK  = 32'h9;
    localparam logic [31:0] CODE_RI   = 32'ha;
    localparam logic [31:0] CODE_OV   = 32'hc;
    localparam logic [31:0] CODE_TRAP = 32'hd;
    localparam logic [31:0] CODE_ERET = 32'he;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   int_pend_q, int_pend_d;

    logic        int_req;
    logic        trap_flag;
    logic        issue;
    logic [31:0] code;
    logic [31:0] bad_addr;
    logic        take_int;

    // Status bits outside IE/EXL/IM, and Cause bits outside IP, play no part
    // here. Their reduction is kept only so the full buses stay connected.
    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    // Interrupt request: globally enabled (IE=1), not already in an
    // exception (EXL=0), and at least one unmasked pending line.
    assign int_req = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

`ifdef TRAP_EXC_EN
    assign trap_flag = exc_trap_i;
`else
    // Trap support compiled out: the input is deliberately ignored.
    logic unused_trap;
    assign unused_trap = exc_trap_i;
    assign trap_flag   = 1'b0;
`endif

    // Exceptions may be raised only for a real, unstalled instruction while
    // not squashing the shadow of a previous flush. Reset forces the
    // combinational outputs quiet even though the inputs may be live.
    assign issue = ~rst & (state_q == ST_RUN) & ~stall_i & valid_i;

    // Fixed-priority cause selection. bad_addr follows the winning cause, so
    // an address error on fetch reports the PC even if a data address error
    // is also flagged.
    always_comb begin
        code     = CODE_NONE;
        bad_addr = 32'h0;
        if (issue) begin
            if (int_pend_q) begin
                code = CODE_INT;
            end else if (exc_adel_if_i) begin
                code     = CODE_ADEL;
                bad_addr = pc_i;
            end else if (exc_ri_i) begin
                code = CODE_RI;
            end else if (exc_sys_i) begin
                code = CODE_SYS;
            end else if (exc_brk_i) begin
                code = CODE_BRK;
            end else if (trap_flag) begin
                code = CODE_TRAP;
            end else if (exc_ov_i) begin
                code = CODE_OV;
            end else if (exc_adel_i) begin
                code     = CODE_ADEL;
                bad_addr = mem_addr_i;
            end else if (exc_ades_i) begin
                code     = CODE_ADES;
                bad_addr = mem_addr_i;
            end else if (eret_i) begin
                code = CODE_ERET;
            end
        end
    end

    assign take_int = issue & int_pend_q;

    assign excepttype_o        = code;
    assign bad_addr_o          = bad_addr;
    assign flush_o             = (code != CODE_NONE);
    assign newpc_o             = !flush_o            ? 32'h0 :
                                 (code == CODE_ERET) ? epc_i : EXC_VECTOR;
    assign current_inst_addr_o = pc_i;
    assign is_in_delayslot_o   = is_in_delayslot_i;

    // Next-state logic. The pending-interrupt flag freezes during a stall.
    // It is cleared on the edge that takes the interrupt, and otherwise
    // re-samples the live request. A bubble therefore leaves it set, so
    // the interrupt waits for the next real instruction.
    always_comb begin
        state_d    = state_q;
        int_pend_d = int_pend_q;
        if (!stall_i) begin
            int_pend_d = take_int ? 1'b0 : int_req;
        end
        case (state_q)
            ST_RUN: begin
                if (flush_o) begin
                    state_d = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                if (!stall_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
        end
    end

endmodule

// File: tb/tb_except_unit.sv
// -----------------------------------------------------------------------------
// tb_except_unit
//
// Directed testbench for except_unit. Inputs change 1 time unit after a rising
// edge. The combinational outputs are checked 1 unit later, well clear of the
// next edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_except_unit;

    localparam logic [31:0] VEC = 32'hBFC00380;
`ifdef TRAP_EXC_EN
    localparam logic [31:0] TRAP_EXP    = 32'hd;
    localparam logic [31:0] TRAP_OV_EXP = 32'hd;
`else
    localparam logic [31:0] TRAP_EXP    = 32'h0;
    localparam logic [31:0] TRAP_OV_EXP = 32'hc;
`endif

    logic        clk;
    logic        rst;
    logic        stall_i, valid_i, is_in_delayslot_i;
    logic [31:0] pc_i, mem_addr_i;
    logic        exc_adel_if_i, exc_ri_i, exc_sys_i, exc_brk_i, exc_ov_i;
    logic        exc_adel_i, exc_ades_i, eret_i, exc_trap_i;
    logic [31:0] status_i, cause_i, epc_i;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
    logic        is_in_delayslot_o, flush_o;

    int checks = 0;
    int errors = 0;

    except_unit #(.EXC_VECTOR(VEC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_i             (stall_i),
        .valid_i             (valid_i),
        .pc_i                (pc_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .mem_addr_i          (mem_addr_i),
        .exc_adel_if_i       (exc_adel_if_i),
        .exc_ri_i            (exc_ri_i),
        .exc_sys_i           (exc_sys_i),
        .exc_brk_i           (exc_brk_i),
        .exc_ov_i            (exc_ov_i),
        .exc_adel_i          (exc_adel_i),
        .exc_ades_i          (exc_ades_i),
        .eret_i              (eret_i),
        .exc_trap_i          (exc_trap_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .newpc_o             (newpc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s observed %h expected %h ok", tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        exc_adel_if_i = 0; exc_ri_i = 0; exc_sys_i = 0; exc_brk_i = 0;
        exc_ov_i = 0; exc_adel_i = 0; exc_ades_i = 0; eret_i = 0; exc_trap_i = 0;
    endtask

    // Drop the instruction and spend one unstalled cycle so any SQUASH ends.
    task automatic idle();
        clear_flags();
        valid_i = 0;
        stall_i = 0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; stall_i = 0; valid_i = 0; is_in_delayslot_i = 0;
        pc_i = 0; mem_addr_i = 0; status_i = 0; cause_i = 0; epc_i = 0;
        clear_flags();

        // Reset: live store-misalign inputs must not reach the outputs.
        valid_i = 1; exc_ades_i = 1; mem_addr_i = 32'h12345677;
        tick(); tick();
        check("rst_exctype", excepttype_o, 32'h0);
        check("rst_flush",   {31'h0, flush_o}, 32'h0);
        check("rst_newpc",   newpc_o, 32'h0);
        check("rst_badaddr", bad_addr_o, 32'h0);
        rst = 0;
        idle();

        // Overflow, then the SQUASH cycle suppresses a repeat.
        valid_i = 1; exc_ov_i = 1; pc_i = 32'h80001000; is_in_delayslot_i = 1;
        #1;
        check("ov_code",  excepttype_o, 32'hc);
        check("ov_flush", {31'h0, flush_o}, 32'h1);
        check("ov_newpc", newpc_o, VEC);
        check("ov_bad",   bad_addr_o, 32'h0);
        check("ov_pc",    current_inst_addr_o, 32'h80001000);
        check("ov_ds",    {31'h0, is_in_delayslot_o}, 32'h1);
        tick();
        check("sq_code",  excepttype_o, 32'h0);
        check("sq_flush", {31'h0, flush_o}, 32'h0);
        check("sq_newpc", newpc_o, 32'h0);
        is_in_delayslot_i = 0;
        idle();

        // Store misalign reports the data address.
        valid_i = 1; exc_ades_i = 1; mem_addr_i = 32'h80002003;
        #1;
        check("ades_code", excepttype_o, 32'h5);
        check("ades_bad",  bad_addr_o, 32'h80002003);
        tick(); idle();

        // Fetch misalign beats RI and load misalign; BadVAddr is the PC.
        valid_i = 1; exc_adel_if_i = 1; exc_ri_i = 1; exc_adel_i = 1;
        pc_i = 32'h80003001; mem_addr_i = 32'h80004002;
        #1;
        check("adelif_code", excepttype_o, 32'h4);
        check("adelif_bad",  bad_addr_o, 32'h80003001);
        tick(); idle();

        // Load misalign alone reports the data address.
        valid_i = 1; exc_adel_i = 1; mem_addr_i = 32'h80004002;
        #1;
        check("adel_code", excepttype_o, 32'h4);
        check("adel_bad",  bad_addr_o, 32'h80004002);
        tick(); idle();

        // ERET redirects to EPC.
        valid_i = 1; eret_i = 1; epc_i = 32'h80000200;
        #1;
        check("eret_code",  excepttype_o, 32'he);
        check("eret_newpc", newpc_o, 32'h80000200);
        check("eret_flush", {31'h0, flush_o}, 32'h1);
        tick(); idle();

        // Stall holds off RI+SYS; releasing it issues RI.
        valid_i = 1; exc_ri_i = 1; exc_sys_i = 1; stall_i = 1;
        #1;
        check("stall_code",  excepttype_o, 32'h0);
        check("stall_flush", {31'h0, flush_o}, 32'h0);
        tick();
        check("stall2_code", excepttype_o, 32'h0);
        stall_i = 0;
        #1;
        check("ri_code", excepttype_o, 32'ha);
        tick(); idle();

        // Syscall beats break; break alone gives 0x9.
        valid_i = 1; exc_sys_i = 1; exc_brk_i = 1;
        #1;
        check("sys_code", excepttype_o, 32'h8);
        tick(); idle();
        valid_i = 1; exc_brk_i = 1;
        #1;
        check("brk_code", excepttype_o, 32'h9);
        tick(); idle();

        // Trap, alone and against overflow.
        valid_i = 1; exc_trap_i = 1;
        #1;
        check("trap_code", excepttype_o, TRAP_EXP);
        tick(); idle();
        valid_i = 1; exc_trap_i = 1; exc_ov_i = 1;
        #1;
        check("trapov_code", excepttype_o, TRAP_OV_EXP);
        tick(); idle();

        // Interrupt across two bubbles, taken on the first valid cycle and
        // winning over a simultaneous overflow.
        status_i = 32'h0000FF01; cause_i = 32'h00000400;
        valid_i = 0; exc_ov_i = 1;
        #1;
        check("bub1_code", excepttype_o, 32'h0);
        tick();
        check("bub2_code", excepttype_o, 32'h0);
        tick();
        valid_i = 1;
        #1;
        check("int_code",  excepttype_o, 32'h1);
        check("int_newpc", newpc_o, VEC);
        check("int_bad",   bad_addr_o, 32'h0);
        tick();
        status_i = 32'h0000FF03;    // handler entry sets EXL
        #1;
        check("int_sq_code", excepttype_o, 32'h0);
        tick();
        check("post_int", excepttype_o, 32'hc);
        tick(); idle();
        status_i = 0; cause_i = 0;
        idle();

        // Asynchronous reset while held in SQUASH returns to RUN with no edge.
        valid_i = 1; exc_ov_i = 1;
        #1;
        check("ar_code", excepttype_o, 32'hc);
        tick();
        stall_i = 1;
        #1;
        check("ar_sq_code", excepttype_o, 32'h0);
        tick();
        rst = 1;
        #1;
        check("ar_rst_code", excepttype_o, 32'h0);
        rst = 0; stall_i = 0;
        #1;
        check("ar_run_code", excepttype_o, 32'hc);
        tick(); idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
